// File: rtl/toggle_bank_ctrl.sv
// Toggle-bank sequencer: prescaled single-cycle toggle pulses in walk-up, walk-down, all or round-robin patterns.
// Optional one-shot sweep is built only when TOGGLE_BANK_ONESHOT_EN is defined.
module toggle_bank_ctrl #(
    parameter int N   = 4,
    parameter int DIV = 4,
    localparam int IW = (N > 2) ? $clog2(N) : 1,
    localparam int CW = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          clr,
    input  logic [1:0]    mode,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  toggle_o,
    output logic [IW-1:0] idx_o,
    output logic [1:0]    state_o,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_start_d;
    logic          r_stop_d;
    logic [1:0]    r_mode;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_ptr;
    logic [N-1:0]  r_toggle;

    state_t        w_state_n;
    logic [1:0]    w_mode_n;
    logic [IW-1:0] w_idx_n;
    logic [CW-1:0] w_cnt_n;
    logic [IW-1:0] w_ptr_n;
    logic [N-1:0]  w_toggle_n;
    logic          w_start_e;
    logic          w_stop_e;
    logic          w_tick;
    logic [IW:0]   w_rr;
    logic          w_gnt_vld;
    logic [IW-1:0] w_gnt;

    // First set request at or above the pointer, wrapping; MSB flags a valid grant.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW:0] res;
        int c;
        res = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(p) + k;
            if (c >= N) c = c - N;
            if (!res[IW] && r[c]) res = {1'b1, IW'(c)};
        end
        return res;
    endfunction

    assign w_start_e = start & ~r_start_d;
    assign w_stop_e  = stop & ~r_stop_d;
    assign w_tick    = (r_state == S_RUN) && (r_cnt == CW'(DIV - 1));
    assign w_rr      = rr_pick(req, r_ptr);
    assign w_gnt_vld = w_rr[IW];
    assign w_gnt     = w_rr[IW-1:0];

    always_comb begin
        w_state_n  = r_state;
        w_mode_n   = r_mode;
        w_idx_n    = r_idx;
        w_cnt_n    = r_cnt;
        w_ptr_n    = r_ptr;
        w_toggle_n = '0;
        if (clr) begin
            w_state_n = S_IDLE;
            w_idx_n   = '0;
            w_cnt_n   = '0;
            w_ptr_n   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_e && !w_stop_e) begin
                        w_state_n = S_RUN;
                        w_mode_n  = mode;
                        w_idx_n   = (mode == 2'd1) ? IW'(N - 1) : '0;
                        w_cnt_n   = '0;
                    end
                end
                S_RUN: begin
                    // The prescaler keeps counting in the stop cycle; its tick is dropped if leaving RUN.
                    w_cnt_n = w_tick ? '0 : r_cnt + CW'(1);
                    if (w_stop_e) begin
                        w_state_n = S_PAUSE;
                    end else if (w_tick) begin
                        case (r_mode)
                            2'd0: begin
                                w_toggle_n = {{(N-1){1'b0}}, 1'b1} << r_idx;
                                w_idx_n    = (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
`ifdef TOGGLE_BANK_ONESHOT_EN
                                if (r_idx == IW'(N - 1)) begin
                                    w_state_n = S_IDLE;
                                    w_cnt_n   = '0;
                                end
`endif
                            end
                            2'd1: begin
                                w_toggle_n = {{(N-1){1'b0}}, 1'b1} << r_idx;
                                w_idx_n    = (r_idx == '0) ? IW'(N - 1) : r_idx - IW'(1);
`ifdef TOGGLE_BANK_ONESHOT_EN
                                if (r_idx == '0) begin
                                    w_state_n = S_IDLE;
                                    w_idx_n   = '0;
                                    w_cnt_n   = '0;
                                end
`endif
                            end
                            2'd2: begin
                                w_toggle_n = '1;
`ifdef TOGGLE_BANK_ONESHOT_EN
                                w_state_n  = S_IDLE;
                                w_idx_n    = '0;
                                w_cnt_n    = '0;
`endif
                            end
                            default: begin
                                if (w_gnt_vld) begin
                                    w_toggle_n = {{(N-1){1'b0}}, 1'b1} << w_gnt;
                                    w_idx_n    = w_gnt;
                                    w_ptr_n    = (w_gnt == IW'(N - 1)) ? '0 : w_gnt + IW'(1);
                                end
                            end
                        endcase
                    end
                end
                S_PAUSE: begin
                    if (w_start_e && !w_stop_e) w_state_n = S_RUN;
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_idx_n   = '0;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_stop_d  <= 1'b0;
            r_mode    <= 2'd0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_toggle  <= '0;
        end else begin
            r_state   <= w_state_n;
            r_start_d <= start;
            r_stop_d  <= stop;
            r_mode    <= w_mode_n;
            r_idx     <= w_idx_n;
            r_cnt     <= w_cnt_n;
            r_ptr     <= w_ptr_n;
            r_toggle  <= w_toggle_n;
        end
    end

    assign toggle_o = r_toggle;
    assign idx_o    = r_idx;
    assign state_o  = r_state;
    assign busy     = (r_state == S_RUN);

endmodule

// File: doc/toggle_bank_ctrl.md
Name: toggle_bank_ctrl

Overview:
Sequencer that drives a bank of N toggle flip-flops (rising-edge-triggered toggle inputs) from one controller. It generates single-cycle toggle pulses on a prescaled timebase in one of four patterns: walk up, walk down, all channels, or round-robin arbitration of manual requests. It sits between the board buttons/switches and the LED toggle bank in the lab top level.

Parameters:
N, 4, number of toggle channels driven (2..16)
DIV, 4, clock cycles per step tick (>=2, so every pulse is followed by at least one low cycle)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  level input; rising edge detected internally
stop  in  1  level input; rising edge detected internally
clr  in  1  synchronous clear to IDLE, level-sensitive
mode  in  2  pattern: 0 walk-up, 1 walk-down, 2 all, 3 manual round-robin
req  in  N  manual toggle requests, level, used in mode 3
toggle_o  out  N  registered toggle pulses to the bank, one cycle wide
idx_o  out  clog2(N)  current walk index / last grant
state_o  out  2  0 IDLE, 1 RUN, 2 PAUSE
busy  out  1  high when state is RUN

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset state: state IDLE; toggle_o=0; idx_o=0; prescaler=0; RR pointer=0; edge-detect history=0; latched mode=0; busy=0.
- Edge detection: start_e = start & ~start_d; stop_e = stop & ~stop_d. The _d flops update every cycle.
- FSM, priority order clr > stop_e > start_e:
  - clr in any state: go to IDLE, idx=0, prescaler=0, RR pointer=0.
  - IDLE + start_e: go to RUN, latch mode. idx=0 for mode 0, N-1 for mode 1, 0 otherwise. Prescaler=0.
  - RUN + stop_e: go to PAUSE. Prescaler value is kept.
  - PAUSE + start_e: go to RUN and resume from the held prescaler/idx. Mode is not re-latched.
  - If start_e and stop_e occur in the same cycle, stop wins. start_e in RUN and stop_e in IDLE are ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN, then wraps.
  - tick = RUN and count==DIV-1.
  - Frozen in PAUSE; zero in IDLE.
- Pulse generation:
  - On a tick cycle, toggle_o is loaded with the pattern for the next cycle. Otherwise toggle_o is loaded with 0.
  - Every pulse is therefore exactly 1 cycle wide.
  - First pulse appears DIV cycles after state_o first reads RUN.
- Patterns:
  - mode 0: pulse bit idx, then idx=idx+1, wrapping N-1 to 0.
  - mode 1: pulse bit idx, then idx=idx-1, wrapping 0 to N-1.
  - mode 2: pulse all N bits; idx unchanged.
  - mode 3: grant the first set bit of req searching from RR pointer upward, with wrap. Pulse that bit, set idx=grant and pointer=grant+1 (mod N). If req==0, no pulse and the pointer is unchanged.
- Leaving RUN (stop, clr): any pulse already registered still completes its single cycle. No new pulse is generated after the transition.
- Reset mid-pulse: toggle_o clears immediately (asynchronous).
- idx width: clog2(N), with a minimum of 1. Wrap uses explicit compare, not natural overflow (N need not be a power of 2).

Optional Feature:
Macro TOGGLE_BANK_ONESHOT_EN.
- Defined: one-shot sweep.
  - mode 0/1: the tick that wraps idx (mode 0: N-1 to 0; mode 1: 0 to N-1) still pulses, then the FSM returns to IDLE next cycle and idx resets to 0.
  - mode 2: returns to IDLE after its first pulse.
  - mode 3: unaffected, runs continuously.
- Undefined: all modes run continuously until stop/clr. The logic is absent from the netlist.

Test Plan:
- rst, then start edge, mode=0 (N=4, DIV=4) -> toggle_o pulses 0001, 0010, 0100, 1000, 0001, spaced 4 cycles, each 1 cycle wide; first pulse 4 cycles after state_o=1.
- mode=1 start -> pulses 1000, 0100, 0010, 0001, 1000; idx_o follows 3, 2, 1, 0, 3.
- mode=0, stop edge 2 cycles after a tick -> state_o=2, no pulses for 20 cycles; start edge -> next pulse 2 cycles after state_o=1, continuing the index sequence.
- mode=3, req=1010 -> pulses 0010, 1000, 0010; then req=0000 -> no pulses, pointer held; req=0001 -> pulse 0001.
- start and stop edges in the same cycle from IDLE -> stays IDLE. clr asserted in RUN -> state_o=0 and idx_o=0 next cycle, no further pulses. rst asserted mid-pulse -> toggle_o=0 at once.
- With TOGGLE_BANK_ONESHOT_EN, mode=0 -> exactly 4 pulses, then state_o=0. mode=2 -> one 1111 pulse, then IDLE. Without the macro -> 8+ pulses continue.
